// File: rtl/water_pkg.sv
// Shared level codes, FSM state encoding and level encoder for the water level controller.
package water_pkg;

  localparam int unsigned LVL_W = 2;
  localparam int unsigned ST_W  = 2;

  // Level codes consumed by the 7-segment water-level decoder
  localparam logic [LVL_W-1:0] LVL_CRIT = 2'b00;
  localparam logic [LVL_W-1:0] LVL_LOW  = 2'b01;
  localparam logic [LVL_W-1:0] LVL_MID  = 2'b10;
  localparam logic [LVL_W-1:0] LVL_HIGH = 2'b11;

  // Fill state machine encoding
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_FILL  = 2'd1;
  localparam logic [ST_W-1:0] ST_FULL  = 2'd2;
  localparam logic [ST_W-1:0] ST_FAULT = 2'd3;

  // Map filtered {high,mid,low} to {sensor_error, level code}; non-thermometer reads as CRIT
  function automatic logic [LVL_W:0] encode_level(input logic [2:0] probes);
    logic [LVL_W:0] res;
    unique case (probes)
      3'b000:  res = {1'b0, LVL_CRIT};
      3'b001:  res = {1'b0, LVL_LOW};
      3'b011:  res = {1'b0, LVL_MID};
      3'b111:  res = {1'b0, LVL_HIGH};
      default: res = {1'b1, LVL_CRIT};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/probe_debouncer.sv
// Two-flop synchroniser plus debounce filter for one tank level probe.
module probe_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic probe_i,
  output logic filt_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Accept a new value only after it has been stable for DEBOUNCE_CYCLES samples
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser and filter state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= probe_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/water_level_controller.sv
// Reservoir inlet valve sequencer: probe debounce, level encoding, fill FSM with watchdog, pump gating.
module water_level_controller
  import water_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FILL_TIMEOUT    = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic probe_low,
  input  logic probe_mid,
  input  logic probe_high,
  input  logic pump_req,
  input  logic fault_clear,
  output logic level_bit0,
  output logic level_bit1,
  output logic valve_open,
  output logic pump_en,
  output logic fault,
  output logic sensor_error
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(FILL_TIMEOUT - 1);

  logic [2:0]       filt;
  logic [LVL_W:0]   enc;
  logic [LVL_W-1:0] code_q, code_d, code_prev_q;
  logic             se_q, se_d;
  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             valve_q, valve_d;
  logic             fault_q, fault_d;
  logic             pump_q, pump_d;
  logic             rise;

  probe_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_low (
    .clk(clk), .reset(reset), .probe_i(probe_low),  .filt_o(filt[0]));
  probe_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_mid (
    .clk(clk), .reset(reset), .probe_i(probe_mid),  .filt_o(filt[1]));
  probe_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_high (
    .clk(clk), .reset(reset), .probe_i(probe_high), .filt_o(filt[2]));

  assign enc    = encode_level(filt);
  assign se_d   = enc[LVL_W];
  assign code_d = enc[LVL_W-1:0];
  assign rise   = (code_q > code_prev_q);

  // Fill FSM next state and watchdog; sensor_error beats HIGH, HIGH beats watchdog expiry
  always_comb begin
    state_d = state_q;
    wd_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (se_q) begin
          state_d = ST_FAULT;
        end else if ((code_q == LVL_CRIT) || (code_q == LVL_LOW)) begin
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (se_q) begin
          state_d = ST_FAULT;
        end else if (code_q == LVL_HIGH) begin
          state_d = ST_FULL;
        end else if (rise) begin
          wd_d = '0;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_FAULT;
        end else begin
          wd_d = wd_q + CNT_W'(1);
        end
      end
      ST_FULL: begin
        if (se_q) begin
          state_d = ST_FAULT;
        end else if (code_q != LVL_HIGH) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clear && !se_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decodes, registered alongside the state so they track it exactly
  always_comb begin
    valve_d = (state_d == ST_FILL);
    fault_d = (state_d == ST_FAULT);
    pump_d  = pump_req && (code_q != LVL_CRIT) && (state_q != ST_FAULT);
  end

  // Encoder, FSM, watchdog and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q      <= LVL_CRIT;
      code_prev_q <= LVL_CRIT;
      se_q        <= 1'b0;
      state_q     <= ST_IDLE;
      wd_q        <= '0;
      valve_q     <= 1'b0;
      fault_q     <= 1'b0;
      pump_q      <= 1'b0;
    end else begin
      code_q      <= code_d;
      code_prev_q <= code_q;
      se_q        <= se_d;
      state_q     <= state_d;
      wd_q        <= wd_d;
      valve_q     <= valve_d;
      fault_q     <= fault_d;
      pump_q      <= pump_d;
    end
  end

  assign level_bit0   = code_q[0];
  assign level_bit1   = code_q[1];
  assign sensor_error = se_q;
  assign valve_open   = valve_q;
  assign fault        = fault_q;
  assign pump_en      = pump_q;

endmodule

// File: tb/tb_water_level_controller.sv
// Directed bench for water_level_controller: vector table plus hand-written corner sequences.
module tb_water_level_controller;

  logic clk = 1'b0;
  logic reset, probe_low, probe_mid, probe_high, pump_req, fault_clear;
  logic level_bit0, level_bit1, valve_open, pump_en, fault, sensor_error;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] probes;   // {high, mid, low}
    logic       pump;
    int         hold;
    logic [1:0] code;
    logic       se;
    logic       valve;
    logic       pump_en;
    logic       fault;
  } vec_t;

  vec_t vecs[7];

  water_level_controller #(.DEBOUNCE_CYCLES(4), .FILL_TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .probe_low(probe_low), .probe_mid(probe_mid), .probe_high(probe_high),
    .pump_req(pump_req), .fault_clear(fault_clear),
    .level_bit0(level_bit0), .level_bit1(level_bit1),
    .valve_open(valve_open), .pump_en(pump_en),
    .fault(fault), .sensor_error(sensor_error));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_probes(input logic [2:0] p);
    {probe_high, probe_mid, probe_low} = p;
  endtask

  task automatic cmp(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk(input string name, input logic [1:0] code, input logic se,
                     input logic valve, input logic pmp, input logic flt);
    cmp({name, ".code"},  {level_bit1, level_bit0}, code);
    cmp({name, ".se"},    {1'b0, sensor_error}, {1'b0, se});
    cmp({name, ".valve"}, {1'b0, valve_open},   {1'b0, valve});
    cmp({name, ".pump"},  {1'b0, pump_en},      {1'b0, pmp});
    cmp({name, ".fault"}, {1'b0, fault},        {1'b0, flt});
  endtask

  initial begin
    //          probes  pump hold code   se    valve pump  fault
    vecs[0] = '{3'b000, 1'b1, 6,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{3'b001, 1'b1, 6,  2'b00, 1'b0, 1'b1, 1'b0, 1'b0};  // not yet accepted
    vecs[2] = '{3'b001, 1'b1, 4,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'b011, 1'b1, 10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{3'b111, 1'b1, 10, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{3'b011, 1'b1, 10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};  // hysteresis: no refill at MID
    vecs[6] = '{3'b001, 1'b1, 10, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1; pump_req = 1'b0; fault_clear = 1'b0;
    set_probes(3'b000);
    #3;
    chk("in_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    chk("in_reset_clocked", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    pump_req = 1'b1;
    tick(1);
    chk("fill_after_reset", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 7; i++) begin
      set_probes(vecs[i].probes);
      pump_req = vecs[i].pump;
      tick(vecs[i].hold);
      chk($sformatf("vec%0d", i), vecs[i].code, vecs[i].se, vecs[i].valve,
          vecs[i].pump_en, vecs[i].fault);
    end

    // Watchdog: FILL entered 8 edges after vec6 applied (wd=0), expires at wd=15
    tick(13);
    chk("wd_before_expiry", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1);
    chk("wd_expired", 2'b01, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk("wd_pump_off", 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk("wd_cleared_idle", 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("wd_refill", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);

    // Rise to MIDDLE then a 3-cycle glitch on the high probe
    set_probes(3'b011);
    tick(8);
    chk("mid_reached", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    probe_high = 1'b1;
    tick(3);
    probe_high = 1'b0;
    tick(5);
    chk("glitch_rejected", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

    // HIGH arrives in the very cycle the watchdog hits FILL_TIMEOUT-1: must go FULL
    set_probes(3'b111);
    tick(8);
    chk("high_at_expiry", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);

    // Non-thermometer pattern 101
    set_probes(3'b101);
    tick(8);
    chk("sensor_error", 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    tick(2);
    chk("clear_ignored", 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
    set_probes(3'b111);
    tick(8);
    chk("error_gone_still_fault", 2'b11, 1'b0, 1'b0, 1'b0, 1'b1);
    fault_clear = 1'b1;
    tick(1);
    fault_clear = 1'b0;
    chk("cleared_to_idle", 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("idle_at_high", 2'b11, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a fill at MIDDLE
    set_probes(3'b001);
    tick(8);
    chk("refill_low", 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    set_probes(3'b011);
    tick(8);
    chk("refill_mid", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    tick(1);
    chk("post_reset_fill", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(5);
    chk("post_reset_latency", 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("post_reset_mid", 2'b10, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("post_reset_pump", 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
